// File: rtl/btn_pulse_conditioner_if.sv
// Bundle of raw inputs and conditioned outputs for the button/switch conditioner.
// The conditioner sits on the slave side; the consumer/driver uses master.
interface btn_pulse_conditioner_if #(
  parameter int SW_WIDTH = 4
);
  logic                btn_raw;
  logic [SW_WIDTH-1:0] sw_raw;
  logic [SW_WIDTH-1:0] sw_sync;
  logic                btn_level;
  logic                btn_pulse;

  modport master (
    output btn_raw,
    output sw_raw,
    input  sw_sync,
    input  btn_level,
    input  btn_pulse
  );

  modport slave (
    input  btn_raw,
    input  sw_raw,
    output sw_sync,
    output btn_level,
    output btn_pulse
  );
endinterface

// File: rtl/btn_pulse_conditioner.sv
// Synchronises btnC and the switches, debounces the button and emits one
// clock-enable pulse per accepted press for the downstream flip-flop bank.
module btn_pulse_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SW_WIDTH        = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  btn_pulse_conditioner_if.slave  bus
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  generate
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
      $error("DEBOUNCE_CYCLES must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  logic                btn_p0;
  logic                btn_p1;
  logic [SW_WIDTH-1:0] sw_p0;
  logic [SW_WIDTH-1:0] sw_p1;

  state_t              state_q;
  state_t              state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                level_q;
  logic                level_d;
  logic                pulse_q;
  logic                pulse_d;

  // Stage p0/p1: two-flop synchronisers; btn_p1 is the synchronised button.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      btn_p0 <= 1'b0;
      btn_p1 <= 1'b0;
      sw_p0  <= '0;
      sw_p1  <= '0;
    end else begin
      btn_p0 <= bus.btn_raw;
      btn_p1 <= btn_p0;
      sw_p0  <= bus.sw_raw;
      sw_p1  <= sw_p0;
    end
  end

  // Debounce FSM register; level and pulse are registered with the state.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (btn_p1) begin
          state_d = DB_PRESS;
          cnt_d   = '0;
        end
      end
      DB_PRESS: begin
        if (!btn_p1) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_p1) begin
          state_d = DB_RELEASE;
          cnt_d   = '0;
        end
      end
      DB_RELEASE: begin
        if (btn_p1) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == HELD) || (state_d == DB_RELEASE);
  end

  assign bus.sw_sync   = sw_p1;
  assign bus.btn_level = level_q;
  assign bus.btn_pulse = pulse_q;

endmodule

// File: tb/tb_btn_pulse_conditioner.sv
// Randomised and directed bench for btn_pulse_conditioner with a window-based
// reference model of the debounced button.
module tb_btn_pulse_conditioner;

  localparam int D  = 4;
  localparam int SW = 4;

  logic clock;
  logic reset_n;

  btn_pulse_conditioner_if #(.SW_WIDTH(SW)) bus ();

  btn_pulse_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .SW_WIDTH(SW)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int obs_pulses = 0;

  // Reference model: btn_sync is the raw button two edges late; the debounced
  // level flips once the last D+1 synchronised samples all disagree with it.
  logic          m_s1, m_sync;
  logic [SW-1:0] m_sw1, m_sw2;
  logic          m_level, m_pulse;
  bit            hist[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic void model_edge(input logic rn, input logic b, input logic [SW-1:0] s);
    bit all_diff;
    if (!rn) begin
      m_s1 = 1'b0; m_sync = 1'b0; m_sw1 = '0; m_sw2 = '0;
      m_level = 1'b0; m_pulse = 1'b0;
      hist.delete();
    end else begin
      hist.push_back(m_sync);
      if (hist.size() > D + 1) void'(hist.pop_front());
      all_diff = (hist.size() == D + 1);
      foreach (hist[i]) if (hist[i] == m_level) all_diff = 1'b0;
      m_pulse = 1'b0;
      if (all_diff) begin
        m_level = !m_level;
        m_pulse = m_level;
      end
      m_sync = m_s1;
      m_s1   = b;
      m_sw2  = m_sw1;
      m_sw1  = s;
    end
  endfunction

  task automatic tick(input logic rn, input logic b, input logic [SW-1:0] s);
    reset_n     = rn;
    bus.btn_raw = b;
    bus.sw_raw  = s;
    @(posedge clock);
    model_edge(rn, b, s);
    #1;
    chk("sw_sync",   32'(bus.sw_sync),   32'(m_sw2));
    chk("btn_level", 32'(bus.btn_level), 32'(m_level));
    chk("btn_pulse", 32'(bus.btn_pulse), 32'(m_pulse));
    if (bus.btn_pulse) obs_pulses++;
  endtask

  initial begin
    int p0;
    logic b;
    logic [SW-1:0] s;
    int len;

    m_s1 = 0; m_sync = 0; m_sw1 = 0; m_sw2 = 0; m_level = 0; m_pulse = 0;
    reset_n = 1'b0; bus.btn_raw = 1'b1; bus.sw_raw = 4'hF;

    // Reset with button held and switches set; then held button gives one pulse.
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 4'hF);
      chk("rst_level", 32'(bus.btn_level), 32'd0);
      chk("rst_sw", 32'(bus.sw_sync), 32'd0);
    end
    p0 = obs_pulses;
    tick(1'b1, 1'b1, 4'hF);
    tick(1'b1, 1'b1, 4'hF);
    chk("sw_after_rst", 32'(bus.sw_sync), 32'hF);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 4'hF);
    chk("held_thru_rst_pulses", 32'(obs_pulses - p0), 32'd1);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 4'h3);

    // Clean press and release.
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b1, 4'h5);
      chk("press_pulse_timing", 32'(bus.btn_pulse), 32'(i == 2 + D));
      chk("press_level_timing", 32'(bus.btn_level), 32'(i >= 2 + D));
    end
    for (int j = 0; j < 10; j++) begin
      tick(1'b1, 1'b0, 4'hA);
      chk("release_level_timing", 32'(bus.btn_level), 32'(j < 2 + D));
      chk("release_no_pulse", 32'(bus.btn_pulse), 32'd0);
    end

    // Press bounce 1,0,1,0 then steady high.
    p0 = obs_pulses;
    tick(1'b1, 1'b1, 4'h0); tick(1'b1, 1'b0, 4'h0);
    tick(1'b1, 1'b1, 4'h0); tick(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 1'b1, 4'h0);
      chk("bounce_pulse_timing", 32'(bus.btn_pulse), 32'(i == 2 + D));
    end
    chk("bounce_pulses", 32'(obs_pulses - p0), 32'd1);

    // Release bounce while held: 2 cycles low then high again.
    p0 = obs_pulses;
    tick(1'b1, 1'b0, 4'h0); tick(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b1, 4'h0);
      chk("rel_bounce_level", 32'(bus.btn_level), 32'd1);
    end
    chk("rel_bounce_pulses", 32'(obs_pulses - p0), 32'd0);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 4'h0);

    // Three clean press/release cycles.
    p0 = obs_pulses;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 4'h9);
      for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 4'h6);
    end
    chk("repeat_pulses", 32'(obs_pulses - p0), 32'd3);

    // Reset while debouncing a press (cnt = 2), then held button.
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 4'h7);
    tick(1'b0, 1'b1, 4'h7);
    chk("mid_rst_level", 32'(bus.btn_level), 32'd0);
    chk("mid_rst_pulse", 32'(bus.btn_pulse), 32'd0);
    chk("mid_rst_sw", 32'(bus.sw_sync), 32'd0);
    p0 = obs_pulses;
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 1'b1, 4'h7);
      chk("mid_rst_pulse_timing", 32'(bus.btn_pulse), 32'(i == 2 + D));
    end
    chk("mid_rst_pulses", 32'(obs_pulses - p0), 32'd1);

    // Randomised runs of button levels with occasional resets.
    for (int r = 0; r < 600; r++) begin
      b   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) begin
        s = SW'($urandom);
        if ($urandom_range(0, 149) == 0) tick(1'b0, b, s);
        else tick(1'b1, b, s);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
